ca_frame_writer: RTL and testbench
==================================

# ca_frame_writer

Upstream producer for the 1280x1024 monochrome frame buffer (65536 words x 20 bits, dual-port RAM). On each end-of-frame indication from the display scanner, it regenerates the whole frame by evolving a 1-D elementary cellular automaton row by row. It writes 1 word per clock on RAM port A, while the scanner reads 1 word per 20 clocks on port B.

## Interface
Parameters:
- SEED_X, 640, pixel column set in row 0 when restarting (0..1279).
- ROWS, 1024, rows generated per frame (address span = ROWS*64).

Ports:
- clk108  in  1  108 MHz pixel clock; sole clock.
- reset  in  1  synchronous, active-high.
- ready_sig  in  1  end-of-frame level from display scanner; a rising edge requests a frame.
- rule  in  8  Wolfram rule number; sampled on accepted request.
- cont  in  1  0 = restart from seed; 1 = continue from previous frame's state; sampled on accepted request.
- address_a  out  16  port A word address.
- data_a  out  20  port A write data.
- wren_a  out  1  port A write enable.
- busy  out  1  generation in progress.
- done  out  1  single-cycle pulse after the last write.

## Operation
- Pixel mapping:
  - Word address = row*64 + w.
  - Word bit 19 is the leftmost pixel: pixel x = 20*w + (19 - bit).
  - Internally, 1280-bit row register `cur` holds pixel x at bit 1279-x.
- Request: `ready_sig` is high this cycle and was low in the previous cycle (edge-detect register). Requests are ignored while busy.
- FSM IDLE -> GEN -> DONE -> IDLE.
  - IDLE on request: latch `rule` and `cont`, clear word counter `n` (16 bits). If cont=0, load `cur` with a single 1 at SEED_X; if cont=1, leave `cur` unchanged. Go to GEN.
  - GEN, each cycle:
    - Write word w = n[5:0] of `cur` to address n.
    - In parallel, compute next-generation word w into `nxt` from a 22-bit window: the left neighbour bit, the 20 word bits, and the right neighbour bit.
    - When w==63: `cur` <= next generation (nxt words 0..62 plus the word computed this cycle), `nxt` is cleared.
    - When n==ROWS*64-1, go to DONE.
  - DONE: pulse `done`, go to IDLE.
- Rule: new cell = rule[{left,centre,right}].
- Boundary: null boundary; cells outside 0..1279 read as 0. No wrap-around.
- At frame end, `cur` holds the generation after the last row. With cont=1 this becomes row 0 of the next frame, giving page-wise scrolling.
- Reset (any time, including mid-frame):
  - wren_a=0, busy=0, done=0, address_a=0, data_a=0.
  - FSM=IDLE, `cur`=0, `nxt`=0, edge-detect register=0.
  - No partial write completes after reset.
- Tearing: the writer (1 word/clk) starts when the scanner is at word 0 (1 word/20 clk), so it stays ahead of the reader. No extra handshake with the scanner.

## Timing
- All outputs are registered.
- With the request edge sampled in cycle T:
  - busy is high in cycles T+1..T+ROWS*64.
  - wren_a=1 with address_a=n in cycle T+1+n; exactly one write per cycle and no gaps.
  - busy falls and done=1 in cycle T+1+ROWS*64, for exactly one cycle.
- A request coinciding with the done cycle is ignored. The next frame needs a fresh rising edge.
- Changes to rule or cont while busy have no effect until the next accepted request.
- Row transition: the write of word 0 of row r+1 immediately follows word 63 of row r; `cur` update must not insert a bubble.

## Structure
- Package ca_pkg: WORD_W=20, ADDR_W=16, WORDS_PER_ROW=64, ROW_W=1280, and the FSM state enum {IDLE, GEN, DONE}.
- Sub-module ca_rule_word: combinational; 22-bit window + 8-bit rule -> 20-bit next-generation word. Instantiated once, with the window selected by w.

## Test plan
- Rule 90, cont=0, SEED_X=640:
  - addr 32 = 0x80000; all other row-0 words 0.
  - addr 95 = 0x00001 and addr 96 = 0x40000; rest of row 1 zero.
  - done exactly 65537 cycles after the request edge.
- Rule 204 (identity): every row r has word 32 = 0x80000 at address 64r+32; all other words 0. Second frame with cont=1 is identical.
- Rule 2 (left shift): row 640 addr 40960 = 0x80000; rows 641..1023 all zero, confirming the null left boundary.
- Rule 255: row 0 = seed; every word of rows 1..1023 = 0xFFFFF. Rule 0: rows 1..1023 all zero.
- Hold ready_sig high for 40 cycles, then toggle it during GEN: exactly one frame of writes; mid-frame edges are ignored.
- Assert reset at n=1000: wren_a drops the next cycle and busy=0. A new rising edge restarts from address 0 using the seed, since `cur` is cleared.

Source files
------------

// File: rtl/ca_frame_writer_pkg.sv
// Shared constants, FSM state type and row-word helpers for the cellular-automaton frame writer.
package ca_pkg;

   localparam int WORD_W        = 20;
   localparam int ADDR_W        = 16;
   localparam int WORDS_PER_ROW = 64;
   localparam int ROW_W         = 1280;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Word 0 (leftmost pixels) sits at the top of the row vector.
   function automatic logic [10:0] word_lsb(input logic [5:0] w);
      return 11'(6'd63 - w) * 11'd20;
   endfunction

   function automatic logic [WORD_W-1:0] row_word(input logic [ROW_W-1:0] row, input logic [5:0] w);
      return row[word_lsb(w) +: WORD_W];
   endfunction

endpackage

// File: rtl/ca_frame_writer_if.sv
// Frame-buffer RAM port A write bus.
interface ca_frame_writer_if;
   import ca_pkg::*;

   logic [ADDR_W-1:0] address_a;
   logic [WORD_W-1:0] data_a;
   logic              wren_a;

   modport master (output address_a, data_a, wren_a);
   modport slave  (input  address_a, data_a, wren_a);
endinterface

// File: rtl/ca_frame_writer_rule_word.sv
// Applies an elementary CA rule to one 20-cell word given its two outer neighbours.
module ca_rule_word
   import ca_pkg::*;
(
   input  logic [WORD_W+1:0] window,
   input  logic [7:0]        rule,
   output logic [WORD_W-1:0] word
);

   // Each output cell looks up the rule with {left, centre, right}.
   always_comb begin
      word = '0;
      for (int j = 0; j < WORD_W; j++) begin
         word[j] = rule[window[j +: 3]];
      end
   end

endmodule

// File: rtl/ca_frame_writer.sv
// Regenerates the whole frame buffer by evolving a 1-D cellular automaton, one RAM word per clock.
module ca_frame_writer
   import ca_pkg::*;
#(
   parameter int SEED_X = 640,
   parameter int ROWS   = 1024
) (
   input  logic              clk108,
   input  logic              reset,
   input  logic              ready_sig,
   input  logic [7:0]        rule,
   input  logic              cont,
   ca_frame_writer_if.master ram,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_N   = ADDR_W'(ROWS * WORDS_PER_ROW - 1);
   localparam logic [ROW_W-1:0]  SEED_ROW = {{(ROW_W-1){1'b0}}, 1'b1} << (ROW_W - 1 - SEED_X);

   state_t             state;
   logic               ready_q;
   logic [7:0]         rule_q;
   logic [ADDR_W-1:0]  n;
   logic [ROW_W-1:0]   cur;
   logic [ROW_W-1:0]   nxt;

   logic [5:0]         w;
   logic [10:0]        lsb;
   logic [ROW_W+1:0]   padded;
   logic [WORD_W+1:0]  window;
   logic [WORD_W-1:0]  new_word;
   logic [WORD_W-1:0]  next_data;
   logic               request;

   assign w       = n[5:0];
   assign lsb     = word_lsb(w);
   assign padded  = {1'b0, cur, 1'b0};
   assign window  = padded[lsb +: WORD_W+2];
   assign request = ready_sig & ~ready_q;

   ca_rule_word u_rule_word (
      .window (window),
      .rule   (rule_q),
      .word   (new_word)
   );

   // Data for the following write; at a row boundary it comes from the freshly built generation.
   always_comb begin
      if (w == 6'd63) begin
         next_data = nxt[ROW_W-1 -: WORD_W];
      end else begin
         next_data = row_word(cur, w + 6'd1);
      end
   end

   // Frame FSM with registered RAM-port and status outputs.
   always_ff @(posedge clk108) begin
      if (reset) begin
         state         <= IDLE;
         ready_q       <= 1'b0;
         rule_q        <= 8'd0;
         n             <= '0;
         cur           <= '0;
         nxt           <= '0;
         ram.address_a <= '0;
         ram.data_a    <= '0;
         ram.wren_a    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         ready_q <= ready_sig;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (request) begin
                  rule_q        <= rule;
                  n             <= '0;
                  state         <= GEN;
                  busy          <= 1'b1;
                  ram.wren_a    <= 1'b1;
                  ram.address_a <= '0;
                  if (!cont) begin
                     cur        <= SEED_ROW;
                     ram.data_a <= row_word(SEED_ROW, 6'd0);
                  end else begin
                     ram.data_a <= row_word(cur, 6'd0);
                  end
               end
            end
            GEN: begin
               nxt[lsb +: WORD_W] <= new_word;
               // Swap in the next generation without a bubble; later clear wins over the word write.
               if (w == 6'd63) begin
                  cur <= {nxt[ROW_W-1:WORD_W], new_word};
                  nxt <= '0;
               end
               if (n == LAST_N) begin
                  state      <= DONE;
                  ram.wren_a <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  n             <= n + 16'd1;
                  ram.address_a <= n + 16'd1;
                  ram.data_a    <= next_data;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               ram.wren_a <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ca_frame_writer.sv
// Directed bench for ca_frame_writer using a reduced frame (16 rows) and seed column 10.
module tb_ca_frame_writer;
   import ca_pkg::*;

   localparam int ROWS = 16;
   localparam int SEED = 10;
   localparam int NW   = ROWS * WORDS_PER_ROW;
   localparam int NV   = 27;

   logic       clk108 = 1'b0;
   logic       reset;
   logic       ready_sig;
   logic [7:0] rule;
   logic       cont;
   logic       busy;
   logic       done;

   ca_frame_writer_if ram ();

   ca_frame_writer #(.SEED_X(SEED), .ROWS(ROWS)) dut (
      .clk108    (clk108),
      .reset     (reset),
      .ready_sig (ready_sig),
      .rule      (rule),
      .cont      (cont),
      .ram       (ram.master),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk108 = ~clk108;

   typedef struct {
      bit         start;
      logic [7:0] rule;
      bit         cont;
      int         addr;
      int         span;
      logic [19:0] exp;
   } vec_t;

   vec_t        tbl [0:NV-1];
   logic [19:0] mem [0:NW-1];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int nonzero(input int lo, input int len);
      int cnt = 0;
      for (int i = lo; i < lo + len; i++) begin
         if (mem[i] != 20'd0) cnt++;
      end
      return cnt;
   endfunction

   // Launch one frame, capture every write and verify contiguity and done timing.
   task automatic run_frame(input logic [7:0] r, input logic c);
      bit contig;
      int done_cyc;
      for (int i = 0; i < NW; i++) mem[i] = 20'hABCDE;
      @(negedge clk108);
      rule = r; cont = c; ready_sig = 1'b1;
      contig = 1'b1;
      done_cyc = -1;
      for (int cyc = 1; cyc <= NW + 50; cyc++) begin
         @(negedge clk108);
         if (cyc == 3) begin
            rule = ~r; cont = ~c;
         end
         if (cyc == 10) ready_sig = 1'b0;
         if (cyc <= NW) begin
            if (ram.wren_a && busy && !done && ram.address_a == ADDR_W'(cyc - 1))
               mem[cyc-1] = ram.data_a;
            else
               contig = 1'b0;
         end else if (cyc == NW + 1) begin
            if (ram.wren_a || busy) contig = 1'b0;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      check($sformatf("frame_r%0d_writes", r), 32'(contig), 32'd1);
      check($sformatf("frame_r%0d_done_latency", r), done_cyc, NW + 1);
      @(negedge clk108);
      check($sformatf("frame_r%0d_done_pulse", r), 32'(done), 32'd0);
   endtask

   initial begin
      int writes, dones, cnt;
      bit seen;

      tbl[0]  = '{1'b1, 8'd90,  1'b0, 0,    0,   20'h00200};
      tbl[1]  = '{1'b0, 8'd90,  1'b0, 1,    0,   20'h00000};
      tbl[2]  = '{1'b0, 8'd90,  1'b0, 64,   0,   20'h00500};
      tbl[3]  = '{1'b0, 8'd90,  1'b0, 65,   0,   20'h00000};
      tbl[4]  = '{1'b0, 8'd90,  1'b0, 128,  0,   20'h00880};
      tbl[5]  = '{1'b0, 8'd90,  1'b0, 64,   64,  20'd1};
      tbl[6]  = '{1'b1, 8'd204, 1'b0, 0,    0,   20'h00200};
      tbl[7]  = '{1'b0, 8'd204, 1'b0, 448,  0,   20'h00200};
      tbl[8]  = '{1'b0, 8'd204, 1'b0, 960,  0,   20'h00200};
      tbl[9]  = '{1'b0, 8'd204, 1'b0, 961,  0,   20'h00000};
      tbl[10] = '{1'b0, 8'd204, 1'b0, 0,    NW,  20'd16};
      tbl[11] = '{1'b1, 8'd204, 1'b1, 960,  0,   20'h00200};
      tbl[12] = '{1'b0, 8'd204, 1'b1, 0,    NW,  20'd16};
      tbl[13] = '{1'b1, 8'd2,   1'b0, 192,  0,   20'h01000};
      tbl[14] = '{1'b0, 8'd2,   1'b0, 640,  0,   20'h80000};
      tbl[15] = '{1'b0, 8'd2,   1'b0, 704,  320, 20'd0};
      tbl[16] = '{1'b1, 8'd255, 1'b0, 0,    0,   20'h00200};
      tbl[17] = '{1'b0, 8'd255, 1'b0, 1,    0,   20'h00000};
      tbl[18] = '{1'b0, 8'd255, 1'b0, 64,   0,   20'hFFFFF};
      tbl[19] = '{1'b0, 8'd255, 1'b0, 1023, 0,   20'hFFFFF};
      tbl[20] = '{1'b1, 8'd170, 1'b1, 0,    0,   20'hFFFFF};
      tbl[21] = '{1'b0, 8'd170, 1'b1, 127,  0,   20'hFFFFE};
      tbl[22] = '{1'b0, 8'd170, 1'b1, 1023, 0,   20'hF8000};
      tbl[23] = '{1'b1, 8'd240, 1'b1, 63,   0,   20'hF0000};
      tbl[24] = '{1'b0, 8'd240, 1'b1, 64,   0,   20'h7FFFF};
      tbl[25] = '{1'b1, 8'd0,   1'b0, 0,    0,   20'h00200};
      tbl[26] = '{1'b0, 8'd0,   1'b0, 64,   960, 20'd0};

      reset = 1'b1; ready_sig = 1'b0; rule = 8'd0; cont = 1'b0;
      repeat (3) @(negedge clk108);
      reset = 1'b0;
      @(negedge clk108);
      check("reset_wren", 32'(ram.wren_a), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_addr", 32'(ram.address_a), 32'd0);
      check("reset_data", 32'(ram.data_a), 32'd0);

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].start) run_frame(tbl[i].rule, tbl[i].cont);
         if (tbl[i].span == 0)
            check($sformatf("vec%0d_r%0d_addr%0d", i, tbl[i].rule, tbl[i].addr),
                  32'(mem[tbl[i].addr]), 32'(tbl[i].exp));
         else begin
            cnt = nonzero(tbl[i].addr, tbl[i].span);
            check($sformatf("vec%0d_r%0d_nonzero%0d", i, tbl[i].rule, tbl[i].addr),
                  cnt, 32'(tbl[i].exp));
         end
      end

      // Level held high then toggled mid-frame: one frame only.
      writes = 0; dones = 0;
      @(negedge clk108);
      rule = 8'd204; cont = 1'b0; ready_sig = 1'b1;
      for (int cyc = 1; cyc <= 1200; cyc++) begin
         @(negedge clk108);
         if (cyc >= 40 && cyc < 900 && (cyc % 7) == 0) ready_sig = ~ready_sig;
         if (cyc == 900) ready_sig = 1'b0;
         if (ram.wren_a) writes++;
         if (done) dones++;
      end
      check("toggle_writes", writes, NW);
      check("toggle_dones", dones, 1);

      // Rising edge landing in the done cycle is ignored.
      seen = 1'b0;
      @(negedge clk108);
      ready_sig = 1'b1;
      for (int cyc = 1; cyc <= NW + 50; cyc++) begin
         @(negedge clk108);
         if (cyc == 5) ready_sig = 1'b0;
         if (done) begin
            seen = 1'b1;
            ready_sig = 1'b1;
            break;
         end
      end
      check("donecyc_seen", 32'(seen), 32'd1);
      writes = 0;
      repeat (30) begin
         @(negedge clk108);
         if (ram.wren_a || busy) writes++;
      end
      check("donecyc_ignored", writes, 0);
      ready_sig = 1'b0;

      // Reset in the middle of a frame.
      seen = 1'b0;
      @(negedge clk108);
      rule = 8'd204; cont = 1'b0; ready_sig = 1'b1;
      for (int cyc = 1; cyc <= NW + 50; cyc++) begin
         @(negedge clk108);
         if (cyc == 5) ready_sig = 1'b0;
         if (ram.wren_a && ram.address_a == 16'd1000) begin
            seen = 1'b1;
            break;
         end
      end
      check("midreset_reached", 32'(seen), 32'd1);
      reset = 1'b1;
      @(negedge clk108);
      reset = 1'b0;
      check("midreset_wren", 32'(ram.wren_a), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_addr", 32'(ram.address_a), 32'd0);
      check("midreset_data", 32'(ram.data_a), 32'd0);
      repeat (3) @(negedge clk108);
      check("midreset_quiet", 32'(ram.wren_a | busy | done), 32'd0);
      run_frame(8'd204, 1'b1);
      check("postreset_cont_cleared", nonzero(0, NW), 0);
      run_frame(8'd204, 1'b0);
      check("postreset_seed", 32'(mem[0]), 32'h00200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
